shift_scheduler: RTL and testbench

- Time-shares one registered 32-bit left-shift unit (base << power, one-cycle latency) among NUM_REQ neuron requesters.
- Picks requests round-robin, drives the shifter operands and waits out the fixed shifter latency.
- Returns each result, tagged with the requester index, over a valid/ready response channel.
- Sits between the neuron scaling stages and the single shared shift unit in the network datapath.

---
 rtl/shift_sched_pkg.sv | 22 ++
 rtl/shift_scheduler_rr_arbiter.sv | 28 ++
 rtl/shift_scheduler.sv | 154 +++++++++++++++
 tb/tb_shift_scheduler.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_sched_pkg.sv
// Shared constants, FSM encoding and overflow helper for shift_scheduler.
package shift_sched_pkg;

  localparam int DATA_W    = 32;
  localparam int MAX_SHIFT = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  // True when the shift loses set bits above bit 31 or the amount is out of range.
  function automatic logic shl_overflow(input logic [DATA_W-1:0] base,
                                        input logic [DATA_W-1:0] power);
    logic [2*DATA_W-1:0] wide;
    wide = {{DATA_W{1'b0}}, base} << power[4:0];
    return (power >= DATA_W'(MAX_SHIFT)) || (|wide[2*DATA_W-1:DATA_W]);
  endfunction

endpackage

// File: rtl/shift_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr wins.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               grant_valid
);

  // Scan from farthest to nearest so the candidate closest to ptr is written last.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NUM_REQ]) begin
        grant                                = '0;
        grant[(int'(ptr) + k) % NUM_REQ]     = 1'b1;
        grant_idx                            = IDX_W'((int'(ptr) + k) % NUM_REQ);
        grant_valid                          = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shift_scheduler.sv
// Time-shares one external left-shift unit among NUM_REQ requesters, round-robin.
// Optional overflow flag output rsp_ovf is enabled with SHIFT_SCHED_OVF_EN.
module shift_scheduler
  import shift_sched_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int IDX_W     = 2,
  parameter int SHIFT_LAT = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*DATA_W-1:0] req_base,
  input  logic [NUM_REQ*DATA_W-1:0] req_power,
  output logic [DATA_W-1:0]         sh_base,
  output logic [DATA_W-1:0]         sh_power,
  input  logic [DATA_W-1:0]         sh_result,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [IDX_W-1:0]          rsp_idx,
`ifdef SHIFT_SCHED_OVF_EN
  output logic                      rsp_ovf,
`endif
  output logic                      busy
);

  localparam int CNT_W = 2;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [DATA_W-1:0]   base_q, base_d;
  logic [DATA_W-1:0]   power_q, power_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
`ifdef SHIFT_SCHED_OVF_EN
  logic                ovf_q, ovf_d;
  logic                rsp_ovf_q, rsp_ovf_d;
`endif

  logic [NUM_REQ-1:0]  grant;
  logic [IDX_W-1:0]    grant_idx;
  logic                grant_valid;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req         (req_valid),
    .ptr         (rr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    idx_d       = idx_q;
    base_d      = base_q;
    power_d     = power_q;
    cnt_d       = cnt_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
`ifdef SHIFT_SCHED_OVF_EN
    ovf_d       = ovf_q;
    rsp_ovf_d   = rsp_ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (grant_valid) begin
          idx_d   = grant_idx;
          base_d  = req_base[32'(grant_idx)*DATA_W +: DATA_W];
          power_d = req_power[32'(grant_idx)*DATA_W +: DATA_W];
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CNT_W'(SHIFT_LAT - 1);
`ifdef SHIFT_SCHED_OVF_EN
        ovf_d   = shl_overflow(base_q, power_q);
`endif
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          // Out-of-range amounts give zero whatever the shifter returns.
          rsp_data_d  = (power_q >= DATA_W'(MAX_SHIFT)) ? '0 : sh_result;
          rsp_valid_d = 1'b1;
`ifdef SHIFT_SCHED_OVF_EN
          rsp_ovf_d   = ovf_q;
`endif
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_d        = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_q        <= '0;
      idx_q       <= '0;
      base_q      <= '0;
      power_q     <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
`ifdef SHIFT_SCHED_OVF_EN
      ovf_q       <= 1'b0;
      rsp_ovf_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      base_q      <= base_d;
      power_q     <= power_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
`ifdef SHIFT_SCHED_OVF_EN
      ovf_q       <= ovf_d;
      rsp_ovf_q   <= rsp_ovf_d;
`endif
    end
  end

  // Grants are suppressed while reset is held so nothing is offered before release.
  assign req_ready = (state_q == IDLE && rst_n) ? grant : '0;
  assign sh_base   = base_q;
  assign sh_power  = power_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_idx   = idx_q;
  assign busy      = (state_q != IDLE);
`ifdef SHIFT_SCHED_OVF_EN
  assign rsp_ovf   = rsp_ovf_q;
`endif

endmodule

// File: tb/tb_shift_scheduler.sv
// Self-checking bench for shift_scheduler: directed steps then randomized traffic
// against a rule-level model of arbitration, latency and shift results.
module tb_shift_scheduler;
  import shift_sched_pkg::*;

  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int LAT = 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*32-1:0] req_base;
  logic [N*32-1:0] req_power;
  logic [31:0]     sh_base, sh_power, sh_result;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [31:0]     rsp_data;
  logic [IW-1:0]   rsp_idx;
  logic            busy;
`ifdef SHIFT_SCHED_OVF_EN
  logic            rsp_ovf;
`endif

  logic [31:0] base_a  [N];
  logic [31:0] power_a [N];
  logic [31:0] pipe    [LAT];

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      req_base[i*32 +: 32]  = base_a[i];
      req_power[i*32 +: 32] = power_a[i];
    end
  end

  // External shift unit: only the low five amount bits reach the barrel shifter.
  always @(posedge clk) begin
    pipe[0] <= sh_base << sh_power[4:0];
    for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign sh_result = pipe[LAT-1];

  shift_scheduler #(.NUM_REQ(N), .IDX_W(IW), .SHIFT_LAT(LAT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_base  (req_base),
    .req_power (req_power),
    .sh_base   (sh_base),
    .sh_power  (sh_power),
    .sh_result (sh_result),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_idx   (rsp_idx),
`ifdef SHIFT_SCHED_OVF_EN
    .rsp_ovf   (rsp_ovf),
`endif
    .busy      (busy)
  );

  int          checks = 0;
  int          errors = 0;
  bit          pending = 0;
  int          age = 0;
  int          rr = 0;
  int          exp_idx = 0;
  logic [31:0] exp_data = '0;
  logic [31:0] exp_b = '0;
  logic [31:0] exp_p = '0;
  bit          exp_ovf = 0;
  bit          hs_seen = 0;
  int          hs_idx = 0;
  logic [31:0] last_data = '0;
  bit          last_ovf = 0;
  int          grant_log[$];
  bit          ever_ready[N];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] b, input logic [31:0] p);
    logic [63:0] w;
    if (p >= 32) return 32'd0;
    w = {32'd0, b} << p;
    return w[31:0];
  endfunction

  function automatic bit ref_ovf(input logic [31:0] b, input logic [31:0] p);
    logic [63:0] w;
    if (p >= 32) return 1'b1;
    w = {32'd0, b} << p;
    return (w[63:32] != 32'd0);
  endfunction

  function automatic int ref_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  // One clock: check mid-cycle against the model, then step past the next rising edge.
  task automatic tick();
    int g;
    #1;
    if (pending) begin
      age++;
      check("busy_active", 32'(busy), 32'd1);
      check("ready_while_busy", 32'(req_ready), 32'd0);
      if (age <= LAT + 1) begin
        check("sh_base", sh_base, exp_b);
        check("sh_power", sh_power, exp_p);
      end
      if (age >= LAT + 2) begin
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("rsp_data", rsp_data, exp_data);
        check("rsp_idx", 32'(rsp_idx), 32'(exp_idx));
`ifdef SHIFT_SCHED_OVF_EN
        check("rsp_ovf", 32'(rsp_ovf), 32'(exp_ovf));
`endif
        if (rsp_valid && rsp_ready) begin
          pending   = 0;
          rr        = (exp_idx + 1) % N;
          last_data = rsp_data;
`ifdef SHIFT_SCHED_OVF_EN
          last_ovf  = rsp_ovf;
`endif
        end
      end else begin
        check("rsp_early", 32'(rsp_valid), 32'd0);
      end
    end else begin
      g = ref_grant(req_valid, rr);
      check("busy_idle", 32'(busy), 32'd0);
      check("rsp_idle", 32'(rsp_valid), 32'd0);
      check("grant", 32'(req_ready), (g < 0) ? 32'd0 : (32'd1 << g));
      if (g >= 0) begin
        pending  = 1;
        age      = 0;
        exp_idx  = g;
        exp_b    = base_a[g];
        exp_p    = power_a[g];
        exp_data = ref_shift(base_a[g], power_a[g]);
        exp_ovf  = ref_ovf(base_a[g], power_a[g]);
        hs_seen  = 1;
        hs_idx   = g;
        grant_log.push_back(g);
      end
    end
    for (int i = 0; i < N; i++) if (req_ready[i]) ever_ready[i] = 1;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    check("rst_req_ready", 32'(req_ready), 32'd0);
    check("rst_sh_base", sh_base, 32'd0);
    check("rst_sh_power", sh_power, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_data", rsp_data, 32'd0);
    check("rst_rsp_idx", 32'(rsp_idx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    pending = 0;
    rr      = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic single_op(input int idx, input logic [31:0] b, input logic [31:0] p);
    req_valid      = '0;
    base_a[idx]    = b;
    power_a[idx]   = p;
    req_valid[idx] = 1'b1;
    hs_seen        = 0;
    for (int t = 0; t < 20 && !hs_seen; t++) tick();
    req_valid = '0;
    for (int t = 0; t < 30 && pending; t++) tick();
    check("op_complete", 32'(pending), 32'd0);
  endtask

  task automatic wait_grants(input int n);
    for (int t = 0; t < 400 && grant_log.size() < n; t++) begin
      hs_seen = 0;
      tick();
      if (hs_seen) begin
        base_a[hs_idx]  = $urandom;
        power_a[hs_idx] = $urandom_range(0, 35);
      end
    end
    check("grant_count", 32'(grant_log.size() >= n), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      base_a[i]  = $urandom;
      power_a[i] = $urandom_range(0, 31);
    end

    // Reset values, with every requester asserting.
    req_valid = '1;
    #2;
    apply_reset();
    req_valid = '0;

    // Single request from requester 2.
    rsp_ready = 1'b1;
    single_op(2, 32'h0000_0003, 32'd4);
    check("single_data", last_data, 32'h0000_0030);

    // All requesters valid: strict rotation from requester 0.
    apply_reset();
    grant_log.delete();
    req_valid = '1;
    wait_grants(8);
    for (int i = 0; i < 8 && i < grant_log.size(); i++)
      check("rotation", 32'(grant_log[i]), 32'(i % N));

    // Back-pressure: response held for 10 cycles with requesters waiting.
    rsp_ready = 1'b0;
    for (int t = 0; t < 20 && !(pending && age >= LAT + 2); t++) tick();
    repeat (10) tick();
    check("bp_busy", 32'(busy), 32'd1);
    rsp_ready = 1'b1;
    for (int t = 0; t < 10 && pending; t++) tick();
    req_valid = '0;
    for (int t = 0; t < 10 && pending; t++) tick();

    // Overflow boundaries.
    single_op(1, 32'hFFFF_FFFF, 32'd32);
    check("ovf32_data", last_data, 32'd0);
`ifdef SHIFT_SCHED_OVF_EN
    check("ovf32_flag", 32'(last_ovf), 32'd1);
`endif
    single_op(3, 32'hFFFF_FFFF, 32'd31);
    check("ovf31_data", last_data, 32'h8000_0000);
`ifdef SHIFT_SCHED_OVF_EN
    check("ovf31_flag", 32'(last_ovf), 32'd1);
`endif
    single_op(0, 32'h0000_0001, 32'd31);
    check("one31_data", last_data, 32'h8000_0000);
`ifdef SHIFT_SCHED_OVF_EN
    check("one31_flag", 32'(last_ovf), 32'd0);
`endif

    // Reset while waiting on the shifter.
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    for (int t = 0; t < 20 && !(pending && age == 1); t++) tick();
    apply_reset();
    // Reset while a response is being held.
    req_valid = 4'b1000;
    for (int t = 0; t < 20 && !(pending && age == LAT + 1); t++) tick();
    #1;
    check("pre_reset_rsp_valid", 32'(rsp_valid), 32'd1);
    apply_reset();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (5) tick();
    grant_log.delete();
    req_valid = '1;
    wait_grants(1);
    if (grant_log.size() > 0) check("post_reset_first", 32'(grant_log[0]), 32'd0);
    req_valid = '0;
    for (int t = 0; t < 10 && pending; t++) tick();

    // Requester 1 drops out while 0 is served.
    apply_reset();
    for (int i = 0; i < N; i++) ever_ready[i] = 0;
    grant_log.delete();
    req_valid = 4'b0011;
    wait_grants(1);
    req_valid = 4'b0100;
    wait_grants(2);
    if (grant_log.size() > 1) check("dropout_next", 32'(grant_log[1]), 32'd2);
    check("dropout_never_ready", 32'(ever_ready[1]), 32'd0);
    req_valid = '0;
    for (int t = 0; t < 10 && pending; t++) tick();

    // Randomized traffic.
    for (int c = 0; c < 1500; c++) begin
      hs_seen = 0;
      tick();
      for (int i = 0; i < N; i++) begin
        if (hs_seen && hs_idx == i) begin
          base_a[i] = $urandom;
          case ($urandom_range(0, 7))
            0:       power_a[i] = $urandom_range(32, 40);
            1:       power_a[i] = $urandom;
            default: power_a[i] = $urandom_range(0, 31);
          endcase
          req_valid[i] = 1'($urandom_range(0, 1));
        end else if (req_valid[i] && $urandom_range(0, 15) == 0) begin
          req_valid[i] = 1'b0;
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
